// File: rtl/reorder_buffer_pkg.sv
// Shared widths and constants for the reorder buffer.
// Tag 0 is reserved as "no tag", so pointers only ever hold 1..ROB_DEPTH.
package reorder_buffer_pkg;
    localparam int ROB_WIDTH  = 4;
    localparam int ROB_DEPTH  = 15;
    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;

    localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;
    localparam logic [REG_WIDTH-1:0] ZERO_REG = '0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ROB_WIDTH-1:0] FIRST_TAG = ROB_WIDTH'(1);
    localparam logic [ROB_WIDTH-1:0] DEPTH_CNT = ROB_WIDTH'(ROB_DEPTH);

    // Pointer advance 1,2,..,ROB_DEPTH,1 -- skips the reserved tag 0
    function automatic logic [ROB_WIDTH-1:0] rob_next(input logic [ROB_WIDTH-1:0] p);
        return (p == DEPTH_CNT) ? FIRST_TAG : p + ROB_WIDTH'(1);
    endfunction
endpackage

// File: rtl/reorder_buffer_entry.sv
// One reorder-buffer slot: busy/ready flags, destination register and result.
// Flush and commit-clear win over allocation, which wins over a CDB write.
module rob_entry
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  alloc_i,
    input  logic [REG_WIDTH-1:0]  alloc_rd_i,
    input  logic                  cdb_wr_i,
    input  logic [DATA_WIDTH-1:0] cdb_value_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [REG_WIDTH-1:0]  rd_o,
    output logic [DATA_WIDTH-1:0] value_o
);
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic [REG_WIDTH-1:0]  rd_q, rd_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        value_d = value_q;
        if (flush_i || clear_i) begin
            busy_d  = FALSE;
            ready_d = FALSE;
            rd_d    = ZERO_REG;
            value_d = '0;
        end else if (alloc_i) begin
            busy_d  = TRUE;
            ready_d = FALSE;
            rd_d    = alloc_rd_i;
            value_d = '0;
        end else if (cdb_wr_i && busy_q) begin
            ready_d = TRUE;
            value_d = cdb_value_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= FALSE;
            ready_q <= FALSE;
            rd_q    <= ZERO_REG;
            value_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            value_q <= value_d;
        end
    end

    assign busy_o  = busy_q;
    assign ready_o = ready_q;
    assign rd_o    = rd_q;
    assign value_o = value_q;
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates in program order, accepts out-of-order CDB
// results, and retires at most one ready head entry per cycle (registered).
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [REG_WIDTH-1:0]  alloc_rd,
    output logic [ROB_WIDTH-1:0]  alloc_tag,
    output logic                  full,
    input  logic                  cdb_valid,
    input  logic [ROB_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_value,
    input  logic [ROB_WIDTH-1:0]  query_tag1,
    input  logic [ROB_WIDTH-1:0]  query_tag2,
    output logic                  query_ready1,
    output logic                  query_ready2,
    output logic [DATA_WIDTH-1:0] query_value1,
    output logic [DATA_WIDTH-1:0] query_value2,
    input  logic                  flush,
    output logic                  commit_valid,
    output logic [REG_WIDTH-1:0]  commit_reg,
    output logic [ROB_WIDTH-1:0]  commit_tag,
    output logic [DATA_WIDTH-1:0] commit_value
);
    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                  cv_q, cv_d;
    logic [REG_WIDTH-1:0]  creg_q, creg_d;
    logic [ROB_WIDTH-1:0]  ctag_q, ctag_d;
    logic [DATA_WIDTH-1:0] cval_q, cval_d;

    // Slot 0 is a constant empty entry so any 4-bit tag indexes safely
    logic [ROB_DEPTH:0]                 ent_busy, ent_ready;
    logic [ROB_DEPTH:0][REG_WIDTH-1:0]  ent_rd;
    logic [ROB_DEPTH:0][DATA_WIDTH-1:0] ent_value;

    logic alloc_fire, commit_fire;

    assign full        = (count_q == DEPTH_CNT);
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && !full && !flush;
    assign commit_fire = ent_busy[head_q] && ent_ready[head_q] && !flush;

    assign ent_busy[0]  = FALSE;
    assign ent_ready[0] = FALSE;
    assign ent_rd[0]    = ZERO_REG;
    assign ent_value[0] = '0;

    for (genvar i = 1; i <= ROB_DEPTH; i++) begin : g_ent
        localparam logic [ROB_WIDTH-1:0] TAG = ROB_WIDTH'(i);
        rob_entry u_ent (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush),
            .alloc_i     (alloc_fire && (tail_q == TAG)),
            .alloc_rd_i  (alloc_rd),
            .cdb_wr_i    (cdb_valid && !flush && (cdb_tag == TAG)),
            .cdb_value_i (cdb_value),
            .clear_i     (commit_fire && (head_q == TAG)),
            .busy_o      (ent_busy[i]),
            .ready_o     (ent_ready[i]),
            .rd_o        (ent_rd[i]),
            .value_o     (ent_value[i])
        );
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + ROB_WIDTH'(alloc_fire) - ROB_WIDTH'(commit_fire);
        cv_d    = commit_fire;
        creg_d  = commit_fire ? ent_rd[head_q]    : ZERO_REG;
        ctag_d  = commit_fire ? head_q            : ZERO_ROB;
        cval_d  = commit_fire ? ent_value[head_q] : '0;
        if (commit_fire) head_d = rob_next(head_q);
        if (alloc_fire)  tail_d = rob_next(tail_q);
        if (flush) begin
            head_d  = FIRST_TAG;
            tail_d  = FIRST_TAG;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= FIRST_TAG;
            tail_q  <= FIRST_TAG;
            count_q <= '0;
            cv_q    <= FALSE;
            creg_q  <= ZERO_REG;
            ctag_q  <= ZERO_ROB;
            cval_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cv_q    <= cv_d;
            creg_q  <= creg_d;
            ctag_q  <= ctag_d;
            cval_q  <= cval_d;
        end
    end

    assign commit_valid = cv_q;
    assign commit_reg   = creg_q;
    assign commit_tag   = ctag_q;
    assign commit_value = cval_q;

    // Operand lookup with same-cycle CDB bypass; a free slot never reports ready
    always_comb begin
        query_ready1 = (query_tag1 == ZERO_ROB) || (ent_busy[query_tag1] &&
                       (ent_ready[query_tag1] || (cdb_valid && cdb_tag == query_tag1)));
        query_ready2 = (query_tag2 == ZERO_ROB) || (ent_busy[query_tag2] &&
                       (ent_ready[query_tag2] || (cdb_valid && cdb_tag == query_tag2)));
        query_value1 = ent_busy[query_tag1] ? ent_value[query_tag1] : '0;
        query_value2 = ent_busy[query_tag2] ? ent_value[query_tag2] : '0;
        if (ent_busy[query_tag1] && cdb_valid && cdb_tag == query_tag1) query_value1 = cdb_value;
        if (ent_busy[query_tag2] && cdb_valid && cdb_tag == query_tag2) query_value2 = cdb_value;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order retire, full/wrap, bypass, flush, reset.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic [3:0]  alloc_tag;
    logic        full;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic [3:0]  query_tag1 = '0, query_tag2 = '0;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        flush = 1'b0;
    logic        commit_valid;
    logic [4:0]  commit_reg;
    logic [3:0]  commit_tag;
    logic [31:0] commit_value;

    int errors = 0;
    int checks = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .flush(flush),
        .commit_valid(commit_valid), .commit_reg(commit_reg),
        .commit_tag(commit_tag), .commit_value(commit_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
    endtask

    task automatic chk_commit(input string tag, input logic v, input logic [4:0] r,
                              input logic [3:0] t, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(commit_valid), 32'(v));
        chk({tag, ".reg"},   32'(commit_reg),   32'(r));
        chk({tag, ".tag"},   32'(commit_tag),   32'(t));
        chk({tag, ".value"}, commit_value,      d);
    endtask

    initial begin
        #12 rst = 1'b1;
        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle.alloc_tag", 32'(alloc_tag), 32'd1);
            chk("idle.full", 32'(full), 32'd0);
            chk("idle.commit_valid", 32'(commit_valid), 32'd0);
            chk("idle.commit_reg", 32'(commit_reg), 32'd0);
        end

        // Three allocations, results arrive out of order, retire in order
        alloc_valid = 1'b1;
        alloc_rd = 5'd3; chk("ooo.tag1", 32'(alloc_tag), 32'd1); tick();
        alloc_rd = 5'd5; chk("ooo.tag2", 32'(alloc_tag), 32'd2); tick();
        alloc_rd = 5'd7; chk("ooo.tag3", 32'(alloc_tag), 32'd3); tick();
        alloc_valid = 1'b0;
        cdb(4'd3, 32'h33); tick();
        chk("ooo.no_commit_tail_ready", 32'(commit_valid), 32'd0);
        cdb(4'd1, 32'h11); tick();
        chk("ooo.no_commit_same_cycle", 32'(commit_valid), 32'd0);
        cdb(4'd2, 32'h22); tick();
        cdb_valid = 1'b0;
        chk_commit("ooo.c1", 1'b1, 5'd3, 4'd1, 32'h11); tick();
        chk_commit("ooo.c2", 1'b1, 5'd5, 4'd2, 32'h22); tick();
        chk_commit("ooo.c3", 1'b1, 5'd7, 4'd3, 32'h33); tick();
        chk_commit("ooo.idle", 1'b0, 5'd0, 4'd0, 32'h0);

        // Flush on empty buffer returns pointers to tag 1
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush0.alloc_tag", 32'(alloc_tag), 32'd1);

        // Fill all 15 entries
        alloc_valid = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            alloc_rd = 5'(i);
            chk("fill.tag", 32'(alloc_tag), 32'(i));
            tick();
        end
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.wrap_tag", 32'(alloc_tag), 32'd1);
        alloc_rd = 5'd9; tick(); alloc_valid = 1'b0;
        chk("fill.ignored_tag", 32'(alloc_tag), 32'd1);
        chk("fill.ignored_full", 32'(full), 32'd1);
        cdb(4'd1, 32'h100); tick(); cdb_valid = 1'b0;
        tick();
        chk_commit("fill.c1", 1'b1, 5'd1, 4'd1, 32'h100);
        chk("fill.not_full", 32'(full), 32'd0);
        chk("fill.wrap_alloc_tag", 32'(alloc_tag), 32'd1);
        alloc_valid = 1'b1; alloc_rd = 5'd20; tick(); alloc_valid = 1'b0;
        chk("wrap.full", 32'(full), 32'd1);
        chk("wrap.alloc_tag", 32'(alloc_tag), 32'd2);

        // Full, head ready, alloc requested in the same cycle
        cdb(4'd2, 32'h222); tick(); cdb_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd21;
        chk("cfa.full_before", 32'(full), 32'd1);
        tick();
        chk_commit("cfa.commit", 1'b1, 5'd2, 4'd2, 32'h222);
        chk("cfa.refused_tag", 32'(alloc_tag), 32'd2);
        chk("cfa.refused_full", 32'(full), 32'd0);
        tick(); alloc_valid = 1'b0;
        chk("cfa.accept_tag", 32'(alloc_tag), 32'd3);
        chk("cfa.accept_full", 32'(full), 32'd1);
        chk_commit("cfa.no_commit", 1'b0, 5'd0, 4'd0, 32'h0);

        // Operand query with CDB bypass, tag 0 and stored value
        query_tag1 = 4'd4; query_tag2 = 4'd0; #1;
        chk("q.busy_not_ready", 32'(query_ready1), 32'd0);
        cdb(4'd4, 32'hAB); #1;
        chk("q.bypass_ready", 32'(query_ready1), 32'd1);
        chk("q.bypass_value", query_value1, 32'hAB);
        chk("q.zero_ready", 32'(query_ready2), 32'd1);
        chk("q.zero_value", query_value2, 32'h0);
        tick(); cdb_valid = 1'b0; #1;
        chk("q.stored_ready", 32'(query_ready1), 32'd1);
        chk("q.stored_value", query_value1, 32'hAB);

        // Flush with 6 in flight, alloc and CDB suppressed
        flush = 1'b1; tick(); flush = 1'b0;
        alloc_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            alloc_rd = 5'(i + 10);
            if (i == 6) cdb(4'd1, 32'h55);
            tick();
        end
        cdb(4'd2, 32'h66); flush = 1'b1; tick();
        flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
        chk("flush.alloc_tag", 32'(alloc_tag), 32'd1);
        chk("flush.full", 32'(full), 32'd0);
        chk("flush.commit_valid", 32'(commit_valid), 32'd0);
        query_tag1 = 4'd1; query_tag2 = 4'd2; #1;
        chk("flush.q1_cleared", 32'(query_ready1), 32'd0);
        chk("flush.q2_cleared", 32'(query_ready2), 32'd0);
        tick();
        chk("flush.still_idle", 32'(commit_valid), 32'd0);

        // Asynchronous reset mid-stream
        alloc_valid = 1'b1;
        alloc_rd = 5'd1; tick();
        alloc_rd = 5'd2; tick();
        alloc_rd = 5'd3; cdb(4'd1, 32'h77); tick();
        alloc_valid = 1'b0; cdb_valid = 1'b0; tick();
        chk_commit("rst.pre_commit", 1'b1, 5'd1, 4'd1, 32'h77);
        #2 rst = 1'b0; #1;
        chk_commit("rst.async", 1'b0, 5'd0, 4'd0, 32'h0);
        chk("rst.alloc_tag", 32'(alloc_tag), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        #3 rst = 1'b1;
        tick();
        chk("rst.after_alloc_tag", 32'(alloc_tag), 32'd1);
        chk("rst.after_commit", 32'(commit_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
